// File: rtl/hog_gradient.sv
// HOG gradient stage: 3x3 kernel -> L1 magnitude and 9-bin (20 deg) unsigned orientation.
// Optional build macro HOG_GRAD_BORDER_DROP_EN: drop border kernels instead of flagging them.
module hog_gradient #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int KERNEL_WIDTH = 9*PIXEL_WIDTH,
  parameter int MAG_WIDTH    = PIXEL_WIDTH+1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    k_valid,
  output logic                    k_ready,
  input  logic [KERNEL_WIDTH-1:0] kernel,
  input  logic                    k_border,
  output logic                    g_valid,
  input  logic                    g_ready,
  output logic [MAG_WIDTH-1:0]    g_mag,
  output logic [3:0]              g_bin,
  output logic                    g_border
);

  localparam int PW = PIXEL_WIDTH;
  localparam int DW = PIXEL_WIDTH + 1;
  localparam int CW = PIXEL_WIDTH + 13;
  localparam logic [12:0] THR [4] = '{13'd373, 13'd859, 13'd1774, 13'd5807};

  logic adv;
  assign adv     = !g_valid || g_ready;
  assign k_ready = adv;

  logic valid_in, border_in;
`ifdef HOG_GRAD_BORDER_DROP_EN
  assign valid_in  = k_valid && !k_border;
  assign border_in = 1'b0;
`else
  assign valid_in  = k_valid;
  assign border_in = k_border;
`endif

  // S1: center differences, fold into upper half-plane, absolute values
  logic [PW-1:0] p01, p10, p12, p21;
  assign p01 = kernel[1*PW +: PW];
  assign p10 = kernel[3*PW +: PW];
  assign p12 = kernel[5*PW +: PW];
  assign p21 = kernel[7*PW +: PW];

  logic [DW-1:0] gx, gy, gx_abs, gy_abs;
  logic          gx_neg_c, gy_zero_c;
  assign gx     = {1'b0, p12} - {1'b0, p10};
  assign gy     = {1'b0, p21} - {1'b0, p01};
  assign gx_abs = gx[DW-1] ? (~gx + 1'b1) : gx;
  assign gy_abs = gy[DW-1] ? (~gy + 1'b1) : gy;
  // Folding negates gx when gy < 0, so only the post-fold sign is kept.
  assign gx_neg_c  = gy[DW-1] ? (!gx[DW-1] && (gx != '0)) : gx[DW-1];
  assign gy_zero_c = (gy == '0);

  logic          v1, b1, neg1, yz1;
  logic [PW-1:0] ax1, ay1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0; b1 <= 1'b0; neg1 <= 1'b0; yz1 <= 1'b0;
      ax1 <= '0; ay1 <= '0;
    end else if (adv) begin
      v1   <= valid_in;
      b1   <= border_in;
      neg1 <= gx_neg_c;
      yz1  <= gy_zero_c;
      ax1  <= gx_abs[PW-1:0];
      ay1  <= gy_abs[PW-1:0];
    end
  end

  // S2: count tangent thresholds met, |gy|*1024 >= |gx|*T
  logic [CW-1:0] lhs, ax_ext;
  logic [2:0]    k_c;
  assign lhs    = {{(CW-PW-10){1'b0}}, ay1, 10'd0};
  assign ax_ext = {{(CW-PW){1'b0}}, ax1};

  always_comb begin
    k_c = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (lhs >= ax_ext * CW'(THR[i])) k_c = k_c + 3'd1;
    end
  end

  logic          v2, b2, neg2, yz2;
  logic [PW-1:0] ax2, ay2;
  logic [2:0]    k2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2 <= 1'b0; b2 <= 1'b0; neg2 <= 1'b0; yz2 <= 1'b0;
      ax2 <= '0; ay2 <= '0; k2 <= '0;
    end else if (adv) begin
      v2   <= v1;
      b2   <= b1;
      neg2 <= neg1;
      yz2  <= yz1;
      ax2  <= ax1;
      ay2  <= ay1;
      k2   <= k_c;
    end
  end

  // S3: bin encode, magnitude, output register
  logic [MAG_WIDTH-1:0] mag_c;
  logic [3:0]           bin_c;

  always_comb begin
    mag_c = MAG_WIDTH'(ax2) + MAG_WIDTH'(ay2);
    if (yz2)       bin_c = 4'd0;
    else if (neg2) bin_c = 4'd8 - {1'b0, k2};
    else           bin_c = {1'b0, k2};
    if (b2) begin
      mag_c = '0;
      bin_c = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_valid  <= 1'b0;
      g_mag    <= '0;
      g_bin    <= 4'd0;
      g_border <= 1'b0;
    end else if (adv) begin
      g_valid  <= v2;
      g_mag    <= mag_c;
      g_bin    <= bin_c;
      g_border <= b2;
    end
  end

endmodule
